// File: rtl/operand_stream_feeder.sv
// operand_stream_feeder
//   Holds one layer operand (IFM or weight set) in on-chip storage and streams
//   LANES elements per beat on request. One-cycle read latency, zero-padded
//   tail beat, single-pass or wrap mode, per-pass done pulse.
// Ports
//   clk1, rst                  clock (rising edge), synchronous active-high reset
//   wr_en/wr_addr/wr_data      element load port; addresses >= DEPTH are ignored
//   start, cfg_len, cfg_wrap   start pulse with stream length and wrap mode
//   rd_req                     request one beat this cycle
//   out_data/out_valid         registered beat; data is zero when not valid
//   pass_done                  pulse alongside the last beat of each pass
//   busy                       high while streaming (ACTIVE)
//   rd_err                     sticky: rd_req seen while IDLE; cleared by start
module operand_stream_feeder #(
    parameter int ELEM_WIDTH = 8,
    parameter int LANES      = 8,
    parameter int DEPTH      = 57600,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                        clk1,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [ADDR_WIDTH-1:0]       wr_addr,
    input  logic [ELEM_WIDTH-1:0]       wr_data,
    input  logic                        start,
    input  logic [ADDR_WIDTH-1:0]       cfg_len,
    input  logic                        cfg_wrap,
    input  logic                        rd_req,
    output logic [LANES*ELEM_WIDTH-1:0] out_data,
    output logic                        out_valid,
    output logic                        pass_done,
    output logic                        busy,
    output logic                        rd_err
);
    // Pointer math carries one extra bit so ptr+LANES never wraps.
    localparam int PW = ADDR_WIDTH + 1;
    localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] DEPTH_W = PW'(DEPTH);
    localparam logic [PW-1:0] LANES_W = PW'(LANES);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    logic [ELEM_WIDTH-1:0] r_mem [DEPTH];

    state_t                             r_state, w_state_nxt;
    logic [PW-1:0]                      r_ptr, w_ptr_nxt;
    logic [PW-1:0]                      r_len, w_len_nxt;
    logic                               r_wrap, w_wrap_nxt;
    logic                               r_err, w_err_nxt;
    logic [LANES-1:0][ELEM_WIDTH-1:0]   r_out_data, w_lane;
    logic                               r_out_valid, r_pass_done;
    logic                               w_beat, w_last;
    logic [PW-1:0]                      w_cfg_len;

    // Storage is intentionally not reset; writes are accepted in any state.
    always_ff @(posedge clk1) begin
        if (wr_en && ({1'b0, wr_addr} < DEPTH_W))
            r_mem[wr_addr[MW-1:0]] <= wr_data;
    end

    // 0 or anything beyond the storage means "whole storage".
    assign w_cfg_len = (cfg_len == '0 || {1'b0, cfg_len} > DEPTH_W) ? DEPTH_W : {1'b0, cfg_len};

    // start has priority over rd_req: a simultaneous request is dropped.
    assign w_beat = (r_state == ACTIVE) && rd_req && !start;
    assign w_last = w_beat && ((r_ptr + LANES_W) >= r_len);

    // Lanes past the stream length read as zero (tail padding); the index is
    // only used when it is below len_q, so it is always inside storage.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [PW-1:0] w_idx;
        assign w_idx     = r_ptr + PW'(g);
        assign w_lane[g] = (w_beat && (w_idx < r_len)) ? r_mem[w_idx[MW-1:0]] : '0;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_len_nxt   = r_len;
        w_wrap_nxt  = r_wrap;
        w_err_nxt   = r_err;
        if (start) begin
            w_state_nxt = ACTIVE;
            w_ptr_nxt   = '0;
            w_len_nxt   = w_cfg_len;
            w_wrap_nxt  = cfg_wrap;
            w_err_nxt   = 1'b0;
        end else if (w_beat) begin
            if (w_last) begin
                w_ptr_nxt = '0;
                if (!r_wrap)
                    w_state_nxt = IDLE;
            end else begin
                w_ptr_nxt = r_ptr + LANES_W;
            end
        end else if (r_state == IDLE && rd_req) begin
            w_err_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_len       <= DEPTH_W;
            r_wrap      <= 1'b0;
            r_err       <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_pass_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_len       <= w_len_nxt;
            r_wrap      <= w_wrap_nxt;
            r_err       <= w_err_nxt;
            r_out_data  <= w_lane;
            r_out_valid <= w_beat;
            r_pass_done <= w_last;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign pass_done = r_pass_done;
    assign busy      = (r_state == ACTIVE);
    assign rd_err    = r_err;

endmodule
